xil_bram_tdp_1clk_ctl: RTL and testbench

// - Next-generation single-clock true-dual-port block RAM controller.
// - Adds to the plain TDP RAM wrapper: per-lane byte-write enables, a configurable read

---
 rtl/xil_bram_tdp_1clk_ctl.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_xil_bram_tdp_1clk_ctl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xil_bram_tdp_1clk_ctl.sv
//------------------------------------------------------------------------------
// xil_bram_tdp_1clk_ctl
//
// Single-clock true-dual-port block RAM controller. It wraps a DEP x DAT
// memory with two independent ports, and adds these features:
//   - per-lane byte-write enables (lanes of BEW bits; the top lane may be partial)
//   - a DEL-cycle read pipeline with a one-cycle valid strobe per accepted read
//   - read-first behaviour, on the same port and across ports
//   - deterministic resolution of write-write collisions (PRIA picks the winner)
//   - a memory-clear state machine. It runs after reset when CLRST=1, or on clrreq.
//
// Optional feature macro: XIL_BRAM_TDP_PARITY_EN
//   When defined, each lane stores one even-parity bit. The parity is checked on
//   every read and any mismatch is reported on perrX, aligned with vldX. When
//   undefined, no parity is stored and perra/perrb are tied low.
//
// Ports
//   clka            clock; all state changes on the rising edge
//   rsta            synchronous active-low reset
//   adrX            port X address (ADR bits)
//   wenX / benX     port X write request / per-lane write enables (NBE bits)
//   wdaX            port X write data (DAT bits)
//   renX            port X read request
//   rdaX / vldX     port X read data (held between strobes) / read-valid strobe
//   perrX           port X parity error, aligned with vldX
//   clrreq          start a full-memory clear (honoured only in RUN)
//   clrbsy          clear in progress; user requests are dropped while high
//   colerr          one-cycle pulse after both ports write the same address
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module xil_bram_tdp_1clk_ctl #(
    parameter int ADR   = 10,
    parameter int DAT   = 18,
    parameter int DEP   = 1024,
    parameter int BEW   = 9,
    parameter int DEL   = 1,
    parameter int CLRST = 1,
    parameter int PRIA  = 1
) (
    input  logic                         clka,
    input  logic                         rsta,
    input  logic [ADR-1:0]               adra,
    input  logic                         wena,
    input  logic [(DAT+BEW-1)/BEW-1:0]   bena,
    input  logic [DAT-1:0]               wdaa,
    input  logic                         rena,
    output logic [DAT-1:0]               rdaa,
    output logic                         vlda,
    input  logic [ADR-1:0]               adrb,
    input  logic                         wenb,
    input  logic [(DAT+BEW-1)/BEW-1:0]   benb,
    input  logic [DAT-1:0]               wdab,
    input  logic                         renb,
    output logic [DAT-1:0]               rdab,
    output logic                         vldb,
    input  logic                         clrreq,
    output logic                         clrbsy,
    output logic                         colerr,
    output logic                         perra,
    output logic                         perrb
);

    localparam int NBE = (DAT + BEW - 1) / BEW;
    localparam int AW  = (DEP > 1) ? $clog2(DEP) : 1;
`ifdef XIL_BRAM_TDP_PARITY_EN
    localparam int PW  = NBE;
`else
    localparam int PW  = 0;
`endif
    // A stored word is the data, with the per-lane parity bits above it when enabled.
    localparam int MW  = DAT + PW;

    typedef enum logic {
        RUN = 1'b0,
        CLR = 1'b1
    } state_t;

    //--------------------------------------------------------------------------
    // Helper functions
    //--------------------------------------------------------------------------
`ifdef XIL_BRAM_TDP_PARITY_EN
    // Even parity per lane: the stored bit makes the lane's total bit count even.
    function automatic logic [NBE-1:0] lane_par(input logic [DAT-1:0] d);
        logic [NBE-1:0] p;
        p = '0;
        for (int k = 0; k < NBE; k++) begin
            for (int b = 0; b < BEW; b++) begin
                if (k * BEW + b < DAT) begin
                    p[k] = p[k] ^ d[k * BEW + b];
                end
            end
        end
        return p;
    endfunction

    function automatic logic par_err(input logic [MW-1:0] w);
        return |(lane_par(w[DAT-1:0]) ^ w[MW-1:DAT]);
    endfunction
`endif

    // Expand lane enables into a bit mask over the stored word (data + parity).
    function automatic logic [MW-1:0] lane_mask(input logic [NBE-1:0] be);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < DAT; i++) begin
            m[i] = be[i / BEW];
        end
`ifdef XIL_BRAM_TDP_PARITY_EN
        for (int k = 0; k < NBE; k++) begin
            m[DAT + k] = be[k];
        end
`endif
        return m;
    endfunction

    function automatic logic [MW-1:0] enc_word(input logic [DAT-1:0] d);
`ifdef XIL_BRAM_TDP_PARITY_EN
        return {lane_par(d), d};
`else
        return d;
`endif
    endfunction

    //--------------------------------------------------------------------------
    // Storage and state
    //--------------------------------------------------------------------------
    logic [MW-1:0]  mem [DEP];

    state_t         state_q;
    logic [AW-1:0]  clrcnt_q;
    logic           clrbsy_q;

    logic           colerr_q, colerr_d;
    logic [DEL-1:0] vla_q, vla_d;
    logic [DEL-1:0] vlb_q, vlb_d;
    logic [MW-1:0]  pda_q [DEL];
    logic [MW-1:0]  pda_d [DEL];
    logic [MW-1:0]  pdb_q [DEL];
    logic [MW-1:0]  pdb_d [DEL];

    //--------------------------------------------------------------------------
    // Request qualification
    //--------------------------------------------------------------------------
    logic          run;
    logic          in_a, in_b;
    logic          acc_ra, acc_rb;
    logic          acc_wa, acc_wb;
    logic          coll;
    logic          clr_we;
    logic [MW-1:0] rw_a, rw_b;
    logic [MW-1:0] mask_a, mask_b;
    logic [MW-1:0] word_a, word_b;

    assign run    = rsta && (state_q == RUN);
    assign in_a   = ($unsigned(32'(adra)) < $unsigned(32'(DEP)));
    assign in_b   = ($unsigned(32'(adrb)) < $unsigned(32'(DEP)));
    assign acc_ra = run && rena;
    assign acc_rb = run && renb;
    // Writes to addresses beyond DEP-1 are discarded.
    assign acc_wa = run && wena && in_a;
    assign acc_wb = run && wenb && in_b;
    assign coll   = acc_wa && acc_wb && (adra == adrb);
    assign clr_we = rsta && (state_q == CLR);

    // Out-of-range reads return an all-zero word, which also checks clean.
    assign rw_a   = in_a ? mem[adra[AW-1:0]] : '0;
    assign rw_b   = in_b ? mem[adrb[AW-1:0]] : '0;

    assign mask_a = lane_mask(bena);
    assign mask_b = lane_mask(benb);
    assign word_a = enc_word(wdaa);
    assign word_b = enc_word(wdab);

    //--------------------------------------------------------------------------
    // Write merge
    // On a same-address collision, only the winning port writes. It writes the
    // union of both lane masks. Lanes the winner enabled take the winner's data;
    // the remaining lanes take the loser's data.
    //--------------------------------------------------------------------------
    logic          wr_a_en, wr_b_en;
    logic [MW-1:0] wm_a, wm_b;
    logic [MW-1:0] wd_a, wd_b;
    logic [MW-1:0] nw_a, nw_b;

    always_comb begin
        wr_a_en = acc_wa;
        wr_b_en = acc_wb;
        wm_a    = mask_a;
        wm_b    = mask_b;
        wd_a    = word_a;
        wd_b    = word_b;
        if (coll) begin
            if (PRIA != 0) begin
                wm_a    = mask_a | mask_b;
                wd_a    = (word_a & mask_a) | (word_b & ~mask_a);
                wr_b_en = 1'b0;
            end else begin
                wm_b    = mask_a | mask_b;
                wd_b    = (word_b & mask_b) | (word_a & ~mask_b);
                wr_a_en = 1'b0;
            end
        end
    end

    assign nw_a = (rw_a & ~wm_a) | (wd_a & wm_a);
    assign nw_b = (rw_b & ~wm_b) | (wd_b & wm_b);

    // Memory array. It has no reset, so contents survive reset. The clear and
    // user writes are mutually exclusive because user writes require RUN.
    always_ff @(posedge clka) begin
        if (clr_we) begin
            mem[clrcnt_q] <= '0;
        end
        if (wr_a_en) begin
            mem[adra[AW-1:0]] <= nw_a;
        end
        if (wr_b_en) begin
            mem[adrb[AW-1:0]] <= nw_b;
        end
    end

    //--------------------------------------------------------------------------
    // Clear FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (!rsta) begin
            state_q  <= (CLRST != 0) ? CLR : RUN;
            clrcnt_q <= '0;
            clrbsy_q <= (CLRST != 0);
        end else begin
            case (state_q)
                RUN: begin
                    if (clrreq) begin
                        state_q  <= CLR;
                        clrcnt_q <= '0;
                        clrbsy_q <= 1'b1;
                    end
                end
                CLR: begin
                    if (clrcnt_q == AW'(DEP - 1)) begin
                        state_q  <= RUN;
                        clrcnt_q <= '0;
                        clrbsy_q <= 1'b0;
                    end else begin
                        clrcnt_q <= clrcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    clrcnt_q <= '0;
                    clrbsy_q <= 1'b0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Read pipeline
    // Stage 0 captures the pre-write word at the accepting edge. Each stage
    // loads data only when the valid bit entering it is set, so the last stage
    // (and therefore rdX) holds the most recent result between strobes.
    //--------------------------------------------------------------------------
    always_comb begin
        vla_d    = '0;
        vlb_d    = '0;
        vla_d[0] = acc_ra;
        vlb_d[0] = acc_rb;
        pda_d[0] = acc_ra ? rw_a : pda_q[0];
        pdb_d[0] = acc_rb ? rw_b : pdb_q[0];
        for (int s = 1; s < DEL; s++) begin
            vla_d[s] = vla_q[s-1];
            vlb_d[s] = vlb_q[s-1];
            pda_d[s] = vla_q[s-1] ? pda_q[s-1] : pda_q[s];
            pdb_d[s] = vlb_q[s-1] ? pdb_q[s-1] : pdb_q[s];
        end
    end

    assign colerr_d = coll;

    always_ff @(posedge clka) begin
        if (!rsta) begin
            vla_q    <= '0;
            vlb_q    <= '0;
            colerr_q <= 1'b0;
            for (int s = 0; s < DEL; s++) begin
                pda_q[s] <= '0;
                pdb_q[s] <= '0;
            end
        end else begin
            vla_q    <= vla_d;
            vlb_q    <= vlb_d;
            colerr_q <= colerr_d;
            for (int s = 0; s < DEL; s++) begin
                pda_q[s] <= pda_d[s];
                pdb_q[s] <= pdb_d[s];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign rdaa   = pda_q[DEL-1][DAT-1:0];
    assign rdab   = pdb_q[DEL-1][DAT-1:0];
    assign vlda   = vla_q[DEL-1];
    assign vldb   = vlb_q[DEL-1];
    assign clrbsy = clrbsy_q;
    assign colerr = colerr_q;

`ifdef XIL_BRAM_TDP_PARITY_EN
    assign perra  = vla_q[DEL-1] & par_err(pda_q[DEL-1]);
    assign perrb  = vlb_q[DEL-1] & par_err(pdb_q[DEL-1]);
`else
    assign perra  = 1'b0;
    assign perrb  = 1'b0;
`endif

endmodule

// File: tb/tb_xil_bram_tdp_1clk_ctl.sv
`timescale 1ns/1ps

module tb_xil_bram_tdp_1clk_ctl;

    localparam int ADR = 11;   // one spare address bit so out-of-range addresses exist
    localparam int DAT = 18;
    localparam int DEP = 1024;
    localparam int BEW = 9;
    localparam int DEL = 2;

    logic            clka = 1'b0;
    logic            rsta;
    logic [ADR-1:0]  adra, adrb;
    logic            wena, wenb, rena, renb;
    logic [1:0]      bena, benb;
    logic [DAT-1:0]  wdaa, wdab;
    logic [DAT-1:0]  rdaa, rdab;
    logic            vlda, vldb;
    logic            clrreq, clrbsy, colerr, perra, perrb;

    int ncmp = 0;
    int nerr = 0;

    always #5 clka = ~clka;

    xil_bram_tdp_1clk_ctl #(
        .ADR(ADR), .DAT(DAT), .DEP(DEP), .BEW(BEW), .DEL(DEL), .CLRST(1), .PRIA(1)
    ) dut (
        .clka(clka), .rsta(rsta),
        .adra(adra), .wena(wena), .bena(bena), .wdaa(wdaa), .rena(rena),
        .rdaa(rdaa), .vlda(vlda),
        .adrb(adrb), .wenb(wenb), .benb(benb), .wdab(wdab), .renb(renb),
        .rdab(rdab), .vldb(vldb),
        .clrreq(clrreq), .clrbsy(clrbsy), .colerr(colerr),
        .perra(perra), .perrb(perrb)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wena = 1'b0; wenb = 1'b0; rena = 1'b0; renb = 1'b0; clrreq = 1'b0;
    endtask

    // Single isolated read on port A: no strobe after one edge, strobe after two.
    task automatic rd_a(input int addr, input logic [DAT-1:0] exp, input string tag);
        adra = ADR'(addr); rena = 1'b1;
        tick();
        rena = 1'b0;
        chk({tag, "/early"}, 32'(vlda), 32'd0);
        tick();
        chk({tag, "/vld"}, 32'(vlda), 32'd1);
        chk({tag, "/dat"}, 32'(rdaa), 32'(exp));
        chk({tag, "/perr"}, 32'(perra), 32'd0);
    endtask

    task automatic rd_b(input int addr, input logic [DAT-1:0] exp, input string tag);
        adrb = ADR'(addr); renb = 1'b1;
        tick();
        renb = 1'b0;
        chk({tag, "/early"}, 32'(vldb), 32'd0);
        tick();
        chk({tag, "/vld"}, 32'(vldb), 32'd1);
        chk({tag, "/dat"}, 32'(rdab), 32'(exp));
        chk({tag, "/perr"}, 32'(perrb), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, nva, nvb, nza, nzb, ncol;

        rsta = 1'b0; idle();
        adra = '0; adrb = '0; bena = 2'b11; benb = 2'b11; wdaa = '0; wdab = '0;
        repeat (3) tick();
        chk("rst_clrbsy", 32'(clrbsy), 32'd1);
        chk("rst_vlda",   32'(vlda),   32'd0);
        chk("rst_vldb",   32'(vldb),   32'd0);
        chk("rst_rdaa",   32'(rdaa),   32'd0);
        chk("rst_colerr", 32'(colerr), 32'd0);

        // Power-up clear length
        rsta = 1'b1;
        cnt = 0;
        while (clrbsy === 1'b1 && cnt < 3000) begin tick(); cnt++; end
        chk("pwrup_clr_len", 32'(cnt), 32'd1024);

        // Sweep every address on both ports, back-to-back
        nva = 0; nvb = 0; nza = 0; nzb = 0;
        for (int i = 0; i < DEP + DEL; i++) begin
            if (i < DEP) begin
                rena = 1'b1; renb = 1'b1;
                adra = ADR'(i); adrb = ADR'(DEP - 1 - i);
            end else begin
                rena = 1'b0; renb = 1'b0;
            end
            tick();
            if (vlda) begin nva++; if (rdaa != '0 || perra) nza++; end
            if (vldb) begin nvb++; if (rdab != '0 || perrb) nzb++; end
        end
        chk("sweep_vld_a", 32'(nva), 32'd1024);
        chk("sweep_vld_b", 32'(nvb), 32'd1024);
        chk("sweep_nz_a",  32'(nza), 32'd0);
        chk("sweep_nz_b",  32'(nzb), 32'd0);

        // Lane enables: full write, then low lane only
        adra = 11'd5; wena = 1'b1; bena = 2'b11; wdaa = 18'h3FFFF;
        tick();
        bena = 2'b01; wdaa = 18'h00000;
        tick();
        wena = 1'b0;
        chk("wr_no_vld", 32'(vlda), 32'd0);
        rd_b(5, 18'h3FE00, "lane_b");
        tick();
        chk("rdb_hold_dat", 32'(rdab), 32'h3FE00);
        chk("rdb_hold_vld", 32'(vldb), 32'd0);

        // Full write-write collision, port A wins
        adra = 11'd9; adrb = 11'd9; bena = 2'b11; benb = 2'b11;
        wdaa = 18'h12345; wdab = 18'h0ABCD; wena = 1'b1; wenb = 1'b1;
        tick();
        wena = 1'b0; wenb = 1'b0;
        chk("coll_full_err", 32'(colerr), 32'd1);
        tick();
        chk("coll_err_pulse", 32'(colerr), 32'd0);
        rd_a(9, 18'h12345, "coll_full");

        // Partial collision: A low lane wins, B supplies the high lane
        adra = 11'd10; adrb = 11'd10; bena = 2'b01; benb = 2'b11;
        wdaa = 18'h155AA; wdab = 18'h2A955; wena = 1'b1; wenb = 1'b1;
        tick();
        wena = 1'b0; wenb = 1'b0;
        chk("coll_part_err", 32'(colerr), 32'd1);
        rd_b(10, 18'h2A9AA, "coll_part");

        // Cross-port read during write returns the old word
        adra = 11'd3; bena = 2'b11; wdaa = 18'h00111; wena = 1'b1;
        tick();
        wena = 1'b0;
        rena = 1'b1; adra = 11'd3;
        wenb = 1'b1; adrb = 11'd3; benb = 2'b11; wdab = 18'h00222;
        tick();
        rena = 1'b0; wenb = 1'b0;
        chk("xrw_no_colerr", 32'(colerr), 32'd0);
        tick();
        chk("xrw_vld", 32'(vlda), 32'd1);
        chk("xrw_old", 32'(rdaa), 32'h00111);
        rd_a(3, 18'h00222, "xrw_new");

        // Same-port read-first
        adra = 11'd4; rena = 1'b1; wena = 1'b1; bena = 2'b11; wdaa = 18'h3ABCD;
        tick();
        rena = 1'b0; wena = 1'b0;
        tick();
        chk("rf_vld", 32'(vlda), 32'd1);
        chk("rf_old", 32'(rdaa), 32'h00000);
        rd_a(4, 18'h3ABCD, "rf_new");

        // Back-to-back reads on port A with differing data
        rena = 1'b1; adra = 11'd9;
        tick();
        adra = 11'd10;
        tick();
        chk("b2b_0_vld", 32'(vlda), 32'd1);
        chk("b2b_0", 32'(rdaa), 32'h12345);
        adra = 11'd3;
        tick();
        chk("b2b_1", 32'(rdaa), 32'h2A9AA);
        rena = 1'b0;
        tick();
        chk("b2b_2", 32'(rdaa), 32'h00222);
        tick();
        chk("b2b_end_vld", 32'(vlda), 32'd0);
        chk("b2b_hold", 32'(rdaa), 32'h00222);

        // Out-of-range: write discarded (no alias to @5), read gives 0 with vld
        adra = 11'd1029; wena = 1'b1; bena = 2'b11; wdaa = 18'h11111;
        tick();
        wena = 1'b0;
        rd_a(1029, 18'h00000, "oor_rd");
        rd_a(5, 18'h3FE00, "oor_nowr");

`ifdef XIL_BRAM_TDP_PARITY_EN
        adra = 11'd7; wena = 1'b1; bena = 2'b11; wdaa = 18'h00007;
        tick();
        adra = 11'd8; wdaa = 18'h00008;
        tick();
        wena = 1'b0;
        dut.mem[7] = dut.mem[7] ^ 20'h00001;
        adra = 11'd7; rena = 1'b1;
        tick();
        rena = 1'b0;
        tick();
        chk("par_vld7", 32'(vlda), 32'd1);
        chk("par_err7", 32'(perra), 32'd1);
        rd_a(8, 18'h00008, "par_ok8");
`endif

        // Requested clear, with reset reapplied after 100 cleared words
        clrreq = 1'b1;
        tick();
        clrreq = 1'b0;
        chk("clrreq_bsy", 32'(clrbsy), 32'd1);
        nva = 0; ncol = 0;
        wena = 1'b1; adra = 11'd2; bena = 2'b11; wdaa = 18'h3FFFF; rena = 1'b1;
        wenb = 1'b1; adrb = 11'd2; benb = 2'b11; wdab = 18'h15555; renb = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (vlda || vldb) nva++;
            if (colerr) ncol++;
        end
        rsta = 1'b0;
        tick();
        chk("clr_rst_bsy", 32'(clrbsy), 32'd1);
        chk("clr_rst_vld", 32'(vlda), 32'd0);
        tick();
        rsta = 1'b1;
        cnt = 0;
        while (clrbsy === 1'b1 && cnt < 3000) begin
            tick();
            cnt++;
            if (vlda || vldb) nva++;
            if (colerr) ncol++;
        end
        idle();
        chk("clr_restart_len", 32'(cnt), 32'd1024);
        chk("clr_no_vld", 32'(nva), 32'd0);
        chk("clr_no_colerr", 32'(ncol), 32'd0);
        tick();
        chk("clr_done_vld", 32'(vlda), 32'd0);
        rd_a(2, 18'h00000, "clr_nowr2");
        rd_b(9, 18'h00000, "clr_cleared9");
        rd_a(5, 18'h00000, "clr_cleared5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
